dds_reader: RTL and testbench
=============================

DDS_READER -- requirements
Module: dds_reader

Interface
REQ-001 Parameter PHASE_W, default 24, phase accumulator width.
REQ-002 Parameter ADDR_W, default 8, sine-table address width; address = phase[PHASE_W-1 -: ADDR_W].
REQ-003 Parameter DATA_W, default 8, sample width (signed two's complement).
REQ-004 Parameter BURST_W, default 16, burst counter width.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin generation; sampled only in IDLE.
REQ-008 stop  in  1  single-cycle request to end generation; sampled only in RUN.
REQ-009 tuning_word  in  PHASE_W  phase increment; latched on accepted start.
REQ-010 burst_len  in  BURST_W  sample count, latched on accepted start; exists only with DDS_BURST_EN.
REQ-011 rom_address  out  ADDR_W  address to the sine-table ROM (1-cycle registered read).
REQ-012 rom_q  in  DATA_W  ROM read data, valid the cycle after the address is presented.
REQ-013 sample  out  DATA_W  output sample.
REQ-014 sample_valid  out  1  sample holds valid data.
REQ-015 sample_ready  in  1  consumer accepts; transfer when valid and ready are both high.
REQ-016 busy  out  1  high in RUN and DRAIN.
REQ-017 done  out  1  one-cycle pulse when DRAIN completes.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN on stop or burst exhausted, DRAIN->IDLE when no reads are in flight and the buffer is empty.
REQ-019 On accepted start, phase SHALL be cleared to 0 and tuning_word latched; start outside IDLE SHALL be ignored; stop in IDLE or DRAIN SHALL be ignored.
REQ-020 rom_address SHALL be driven directly from the phase register; a read is issued in a RUN cycle only when (buffered + in-flight - popping this cycle) < 2.
REQ-021 Phase SHALL advance by tuning_word only on an issued read, wrapping modulo 2^PHASE_W; otherwise rom_address SHALL hold stable.
REQ-022 rom_q SHALL be captured into a 2-entry FIFO exactly one cycle after its read was issued; in-flight data SHALL never be dropped, except on reset.
REQ-023 sample/sample_valid SHALL present the FIFO head; sample SHALL be stable while valid is high and ready is low.
REQ-024 With sample_ready held high, throughput SHALL be one sample per cycle; first sample_valid SHALL rise 3 cycles after the edge that accepted start.
REQ-025 Samples SHALL emerge in issue order, unmodified from rom_q.
REQ-026 tuning_word = 0 SHALL produce a constant stream of the value at address 0.
REQ-027 stop in the same cycle as the final burst issue SHALL produce the same DRAIN entry, without any extra sample.
REQ-028 done SHALL pulse in the cycle after the final sample transfer, coincident with busy falling.

Reset
REQ-029 Reset SHALL force IDLE, phase=0, FIFO empty, in-flight flag cleared, sample_valid=0, busy=0, done=0, rom_address=0, sample=0.
REQ-030 Reset mid-operation SHALL discard buffered and in-flight samples; no sample_valid SHALL be asserted in the cycle after reset.

Configuration
REQ-031 With DDS_BURST_EN defined, burst_len SHALL exist; RUN SHALL issue exactly burst_len reads, then enter DRAIN; burst_len=0 SHALL mean continuous generation.
REQ-032 Without DDS_BURST_EN, the port and counter SHALL be absent, and RUN SHALL continue until stop.

Structure
REQ-033 Package dds_pkg SHALL hold the default widths and the FSM state enum.
REQ-034 The 2-entry buffer SHALL be a sub-module, dds_skid_fifo (DATA_W, push/pop/full/empty).

Verification
REQ-035 tuning_word=0x010000, ready=1 -> addresses 0,1,2,..., wrapping at 255; samples 00,01,02,...; one per cycle after 3-cycle latency.
REQ-036 tuning_word=0x400000 -> samples 00,2A,00,D6 repeating.
REQ-037 Ready low for 5 cycles mid-stream -> no loss, no duplicates, order preserved, rom_address stable, at most 2 buffered samples.
REQ-038 DDS_BURST_EN, burst_len=4, tuning_word=0x400000 -> exactly 00,2A,00,D6; done pulses once, in the cycle after the 4th transfer.
REQ-039 stop after 10 transfers with ready toggling -> all issued samples are delivered, then done, then IDLE; a start during DRAIN is ignored.
REQ-040 Reset asserted while busy with 2 buffered samples -> the next cycle shows sample_valid=0, busy=0, rom_address=0; a subsequent start restarts from sample 00.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: default widths and FSM state encoding shared by the DDS reader files.
package dds_pkg;
    localparam int PHASE_W_D = 24;
    localparam int ADDR_W_D  = 8;
    localparam int DATA_W_D  = 8;
    localparam int BURST_W_D = 16;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/dds_reader_if.sv
// dds_reader_if: control, ROM and sample-stream signals of the DDS reader.
// burst_len is present only when DDS_BURST_EN is defined.
interface dds_reader_if
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int BURST_W = BURST_W_D
) ();
    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] tuning_word;
`ifdef DDS_BURST_EN
    logic [BURST_W-1:0] burst_len;
`endif
    logic [ADDR_W-1:0]  rom_address;
    logic [DATA_W-1:0]  rom_q;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, tuning_word, rom_q, sample_ready,
`ifdef DDS_BURST_EN
        output burst_len,
`endif
        input  rom_address, sample, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, tuning_word, rom_q, sample_ready,
`ifdef DDS_BURST_EN
        input  burst_len,
`endif
        output rom_address, sample, sample_valid, busy, done
    );
endinterface

// File: rtl/dds_skid_fifo.sv
// dds_skid_fifo: 2-entry FIFO holding ROM samples; head is presented combinationally.
module dds_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem <= '{default: '0};
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (i_pop)
                r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_full  = r_cnt == 2'd2;
    assign o_empty = r_cnt == 2'd0;
endmodule

// File: rtl/dds_reader.sv
// dds_reader: phase-accumulator DDS that reads a registered sine ROM into a 2-deep buffer.
// Define DDS_BURST_EN to add burst_len and stop automatically after that many reads.
module dds_reader
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int BURST_W = BURST_W_D
) (
    input logic         clock,
    input logic         reset,
    dds_reader_if.slave bus
);
    state_t             r_state, w_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_tw;
    logic               r_inflight;
    logic               r_done;
    logic               w_full, w_empty, w_pop, w_issue, w_last, w_drained;
    logic [1:0]         w_occ;
`ifdef DDS_BURST_EN
    logic [BURST_W-1:0] r_cnt;
    logic [BURST_W-1:0] r_blen;
    assign w_last = w_issue && r_blen != '0 && r_cnt == r_blen - 1'b1;
`else
    assign w_last = 1'b0;
`endif

    // Occupancy after this cycle's pop; at most 2 samples are ever owed to the buffer.
    assign w_pop     = !w_empty && bus.sample_ready;
    assign w_occ     = {w_full, !w_empty && !w_full} + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue   = r_state == RUN && w_occ < 2'd2;
    assign w_drained = !r_inflight && (w_empty || (!w_full && w_pop));

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = (bus.stop || w_last) ? DRAIN : RUN;
            DRAIN:   w_next = w_drained ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase    <= '0;
            r_tw       <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
`ifdef DDS_BURST_EN
            r_cnt      <= '0;
            r_blen     <= '0;
`endif
        end else begin
            r_inflight <= w_issue;
            r_done     <= r_state == DRAIN && w_drained;
            if (r_state == IDLE && bus.start) begin
                r_phase <= '0;
                r_tw    <= bus.tuning_word;
`ifdef DDS_BURST_EN
                r_cnt   <= '0;
                r_blen  <= bus.burst_len;
`endif
            end else if (w_issue) begin
                r_phase <= r_phase + r_tw;
`ifdef DDS_BURST_EN
                r_cnt   <= r_cnt + 1'b1;
`endif
            end
        end
    end

    dds_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  (bus.rom_q),
        .i_pop   (w_pop),
        .o_data  (bus.sample),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rom_address  = r_phase[PHASE_W-1 -: ADDR_W];
    assign bus.sample_valid = !w_empty;
    assign bus.busy         = r_state != IDLE;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_dds_reader.sv
// tb_dds_reader: directed bench for dds_reader with a registered ROM model.
// Burst scenarios run only when DDS_BURST_EN is defined.
module tb_dds_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         last_xfer = -1;
    logic       busy_at_done = 1'b1;
    logic [7:0] q [$];

    dds_reader_if bus ();

    dds_reader dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return a == 8'd64 ? 8'h2A : a == 8'd128 ? 8'h00 : a == 8'd192 ? 8'hD6 : a;
    endfunction

    always @(posedge clk) cyc++;
    always @(posedge clk) bus.rom_q <= rom(bus.rom_address);

    always @(negedge clk) begin
        if (bus.sample_valid && bus.sample_ready) begin
            q.push_back(bus.sample);
            last_xfer = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = bus.busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        last_xfer    = -1;
        busy_at_done = 1'b1;
    endtask

    task automatic start_gen(input logic [23:0] tw, input logic [15:0] bl);
        bus.start       = 1'b1;
        bus.tuning_word = tw;
`ifdef DDS_BURST_EN
        bus.burst_len   = bl;
`else
        if (bl != 16'd0)
            $display("note: burst_len %0d has no effect in this build", bl);
`endif
        tick();
        bus.start = 1'b0;
    endtask

    task automatic stop_gen();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_done_after_last"}, done_cyc, last_xfer + 1);
        check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 0);
    endtask

    task automatic check_ramp(input string tag);
        int errs = 0;
        foreach (q[i])
            if (q[i] !== rom(8'(i))) errs++;
        check({tag, "_order"}, errs, 0);
        check({tag, "_issued_eq_delivered"}, q.size() % 256, {24'd0, bus.rom_address});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int gaps;
        int ch;
        int errs;
        logic [7:0] a0, s0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.tuning_word  = '0;
        bus.sample_ready = 1'b0;
`ifdef DDS_BURST_EN
        bus.burst_len    = '0;
`endif
        repeat (2) tick();
        @(negedge clk);
        check("rst_valid", {31'd0, bus.sample_valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_addr", {24'd0, bus.rom_address}, 0);
        check("rst_sample", {24'd0, bus.sample}, 0);
        tick();
        rst = 1'b0;
        tick();

        // ramp through a full address wrap, ready held high
        clear();
        bus.sample_ready = 1'b1;
        start_gen(24'h010000, 16'd0);
        @(negedge clk) check("lat_c1_valid", {31'd0, bus.sample_valid}, 0);
        @(negedge clk) check("lat_c2_valid", {31'd0, bus.sample_valid}, 0);
        @(negedge clk) check("lat_c3_valid", {31'd0, bus.sample_valid}, 1);
        check("lat_c3_sample", {24'd0, bus.sample}, 0);
        gaps = 0;
        repeat (300) begin
            @(negedge clk);
            if (!bus.sample_valid) gaps++;
        end
        check("ramp_gaps", gaps, 0);
        stop_gen();
        wait_done("ramp");
        check("ramp_len", 32'(q.size() >= 260), 1);
        check("ramp_s1", {24'd0, q[1]}, 32'h01);
        check("ramp_s2", {24'd0, q[2]}, 32'h02);
        check_ramp("ramp");

        // quarter-turn step
        clear();
        tick();
        start_gen(24'h400000, 16'd0);
        repeat (12) tick();
        stop_gen();
        wait_done("quad");
        check("quad_s0", {24'd0, q[0]}, 32'h00);
        check("quad_s1", {24'd0, q[1]}, 32'h2A);
        check("quad_s2", {24'd0, q[2]}, 32'h00);
        check("quad_s3", {24'd0, q[3]}, 32'hD6);
        check("quad_s5", {24'd0, q[5]}, 32'h2A);
        check("quad_s7", {24'd0, q[7]}, 32'hD6);

        // five-cycle stall mid-stream
        clear();
        tick();
        start_gen(24'h010000, 16'd0);
        repeat (12) tick();
        bus.sample_ready = 1'b0;
        @(negedge clk);
        a0 = bus.rom_address;
        s0 = bus.sample;
        check("stall_valid", {31'd0, bus.sample_valid}, 1);
        ch = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rom_address !== a0 || bus.sample !== s0 || !bus.sample_valid) ch++;
        end
        check("stall_stable", ch, 0);
        tick();
        bus.sample_ready = 1'b1;
        repeat (10) tick();
        stop_gen();
        wait_done("stall");
        check_ramp("stall");

        // ready toggling, stop after 10 transfers, start during drain
        clear();
        tick();
        start_gen(24'h010000, 16'd0);
        ch = 0;
        while (q.size() < 10 && ch < 200) begin
            tick();
            bus.sample_ready = ~bus.sample_ready;
            ch++;
        end
        check("tog_reached10", 32'(q.size() >= 10), 1);
        stop_gen();
        bus.start       = 1'b1;
        bus.tuning_word = 24'h400000;
        @(negedge clk) check("tog_drain_busy", {31'd0, bus.busy}, 1);
        tick();
        bus.start        = 1'b0;
        bus.sample_ready = 1'b1;
        wait_done("tog");
        check_ramp("tog");
        repeat (5) tick();
        check("tog_idle_busy", {31'd0, bus.busy}, 0);
        check("tog_idle_valid", {31'd0, bus.sample_valid}, 0);

        // zero tuning word
        clear();
        start_gen(24'h000000, 16'd0);
        repeat (10) tick();
        stop_gen();
        wait_done("tw0");
        errs = 0;
        foreach (q[i])
            if (q[i] !== rom(8'd0)) errs++;
        check("tw0_const", errs, 0);
        check("tw0_len", 32'(q.size() >= 8), 1);

        // reset while two samples are buffered
        clear();
        bus.sample_ready = 1'b0;
        start_gen(24'h010000, 16'd0);
        repeat (6) tick();
        @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 1);
        check("pre_rst_valid", {31'd0, bus.sample_valid}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, bus.sample_valid}, 0);
        check("post_rst_busy", {31'd0, bus.busy}, 0);
        check("post_rst_addr", {24'd0, bus.rom_address}, 0);
        tick();
        clear();
        bus.sample_ready = 1'b1;
        start_gen(24'h010000, 16'd0);
        repeat (8) tick();
        stop_gen();
        wait_done("restart");
        check("restart_s0", {24'd0, q[0]}, 32'h00);
        check("restart_s1", {24'd0, q[1]}, 32'h01);
        check_ramp("restart");

`ifdef DDS_BURST_EN
        // four-sample burst
        clear();
        tick();
        start_gen(24'h400000, 16'd4);
        wait_done("burst");
        check("burst_len", q.size(), 4);
        check("burst_s0", {24'd0, q[0]}, 32'h00);
        check("burst_s1", {24'd0, q[1]}, 32'h2A);
        check("burst_s2", {24'd0, q[2]}, 32'h00);
        check("burst_s3", {24'd0, q[3]}, 32'hD6);

        // stop coincident with the final burst issue
        clear();
        tick();
        start_gen(24'h400000, 16'd4);
        repeat (3) tick();
        stop_gen();
        wait_done("burst_stop");
        check("burst_stop_len", q.size(), 4);
        check("burst_stop_s3", {24'd0, q[3]}, 32'hD6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
